// File: rtl/basket_manager.sv
// basket_manager: shopping-basket table of {ProductID, Quantity} entries with a
// running price total. It sequences add, cancel and clear requests, reads the
// shared price ROM, and applies price*quantity one price step per cycle.
//
// Ports:
//   CLOCK_50, RESET_N        clock, async active-low reset
//   Add_Pulse                1-cycle add request (ProductID_in, Quantity_in)
//   Cancel_Pulse             1-cycle cancel request (CancelIndex_in)
//   Clear_Pulse              1-cycle clear-basket request
//   Price_Addr / Price_Data  price ROM address out, data in (1-cycle latency)
//   Rd_Index                 display read index
//   Rd_ProductID/Rd_Quantity combinational table read (0 beyond count)
//   BasketProductNum         valid entry count
//   Total                    running basket price
//   Busy, Full, Err_Pulse    status: operation active, table full, request rejected
module basket_manager #(
  parameter int unsigned MAX_ITEMS = 8,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned QTY_W     = 4,
  parameter int unsigned PRICE_W   = 8,
  parameter int unsigned TOTAL_W   = 16
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET_N,
  input  logic                         Add_Pulse,
  input  logic                         Cancel_Pulse,
  input  logic                         Clear_Pulse,
  input  logic [ID_W-1:0]              ProductID_in,
  input  logic [QTY_W-1:0]             Quantity_in,
  input  logic [$clog2(MAX_ITEMS)-1:0] CancelIndex_in,
  output logic [ID_W-1:0]              Price_Addr,
  input  logic [PRICE_W-1:0]           Price_Data,
  input  logic [$clog2(MAX_ITEMS)-1:0] Rd_Index,
  output logic [ID_W-1:0]              Rd_ProductID,
  output logic [QTY_W-1:0]             Rd_Quantity,
  output logic [3:0]                   BasketProductNum,
  output logic [TOTAL_W-1:0]           Total,
  output logic                         Busy,
  output logic                         Full,
  output logic                         Err_Pulse
);

  localparam int unsigned IDX_W = $clog2(MAX_ITEMS);
  localparam int unsigned CNT_W = 4;

  localparam logic [QTY_W-1:0]   QTY_MAX   = '1;
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SEARCH     = 3'd1;
  localparam logic [2:0] S_PRICE_REQ  = 3'd2;
  localparam logic [2:0] S_PRICE_WAIT = 3'd3;
  localparam logic [2:0] S_ACCUM      = 3'd4;
  localparam logic [2:0] S_SHIFT      = 3'd5;
  localparam logic [2:0] S_CLEAR      = 3'd6;

  logic [2:0]         state;
  logic [2:0]         state_next;

  logic [ID_W-1:0]    ids  [MAX_ITEMS];
  logic [QTY_W-1:0]   qtys [MAX_ITEMS];
  logic [CNT_W-1:0]   count;
  logic [TOTAL_W-1:0] total;
  logic [ID_W-1:0]    price_addr;
  logic [ID_W-1:0]    op_id;
  logic [QTY_W-1:0]   op_qty;
  logic [QTY_W-1:0]   delta;
  logic [PRICE_W-1:0] price_lat;
  // scan pointer in SEARCH, shift pointer in SHIFT
  logic [CNT_W-1:0]   scan_idx;
  logic               sub_mode;
  logic               err;
  logic               busy;

  logic [IDX_W-1:0]   scan_ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic [IDX_W-1:0]   count_ptr;
  logic [IDX_W-1:0]   last_ptr;
  logic               scan_end;
  logic               scan_hit;
  logic [QTY_W:0]     qty_sum;
  logic [QTY_W-1:0]   qty_new;
  logic               full_c;
  logic               cancel_ok;
  logic               shift_more;
  logic [TOTAL_W:0]   tot_sum;
  logic [TOTAL_W-1:0] tot_add;
  logic [TOTAL_W-1:0] tot_sub;

  // Shared datapath decode
  always_comb begin
    scan_ptr   = scan_idx[IDX_W-1:0];
    next_ptr   = IDX_W'(scan_idx + CNT_W'(1));
    count_ptr  = IDX_W'(count);
    last_ptr   = IDX_W'(count - CNT_W'(1));
    scan_end   = (scan_idx >= count);
    scan_hit   = !scan_end && (ids[scan_ptr] == op_id);
    qty_sum    = {1'b0, qtys[scan_ptr]} + {1'b0, op_qty};
    qty_new    = qty_sum[QTY_W] ? QTY_MAX : qty_sum[QTY_W-1:0];
    full_c     = (count == CNT_W'(MAX_ITEMS));
    cancel_ok  = (CNT_W'(CancelIndex_in) < count);
    shift_more = ((scan_idx + CNT_W'(1)) < count);
    tot_sum    = {1'b0, total} + (TOTAL_W+1)'(price_lat);
    tot_add    = tot_sum[TOTAL_W] ? TOTAL_MAX : tot_sum[TOTAL_W-1:0];
    tot_sub    = (TOTAL_W'(price_lat) > total) ? '0 : (total - TOTAL_W'(price_lat));
  end

  // State register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (Clear_Pulse)       state_next = S_CLEAR;
        else if (Cancel_Pulse) state_next = cancel_ok ? S_PRICE_REQ : S_IDLE;
        else if (Add_Pulse)    state_next = S_SEARCH;
      end
      S_SEARCH: begin
        // a zero-quantity add changes nothing but still completes
        if (op_qty == '0)  state_next = S_IDLE;
        else if (scan_hit) state_next = S_PRICE_REQ;
        else if (scan_end) state_next = full_c ? S_IDLE : S_PRICE_REQ;
      end
      S_PRICE_REQ:  state_next = S_PRICE_WAIT;
      S_PRICE_WAIT: state_next = S_ACCUM;
      S_ACCUM: begin
        if (delta == '0) state_next = sub_mode ? S_SHIFT : S_IDLE;
      end
      S_SHIFT: begin
        if (!shift_more) state_next = S_IDLE;
      end
      S_CLEAR:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath: table, count, total, ROM address and status flags
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < MAX_ITEMS; i++) begin
        ids[i]  <= '0;
        qtys[i] <= '0;
      end
      count      <= '0;
      total      <= '0;
      price_addr <= '0;
      op_id      <= '0;
      op_qty     <= '0;
      delta      <= '0;
      price_lat  <= '0;
      scan_idx   <= '0;
      sub_mode   <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      err  <= 1'b0;
      busy <= (state_next != S_IDLE);
      case (state)
        S_IDLE: begin
          if (Clear_Pulse) begin
            // cleared in S_CLEAR
          end else if (Cancel_Pulse) begin
            if (cancel_ok) begin
              op_id      <= ids[CancelIndex_in];
              delta      <= qtys[CancelIndex_in];
              price_addr <= ids[CancelIndex_in];
              scan_idx   <= CNT_W'(CancelIndex_in);
              sub_mode   <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else if (Add_Pulse) begin
            op_id    <= ProductID_in;
            op_qty   <= Quantity_in;
            scan_idx <= '0;
            sub_mode <= 1'b0;
          end
        end
        S_SEARCH: begin
          if (op_qty != '0) begin
            if (scan_hit) begin
              qtys[scan_ptr] <= qty_new;
              delta          <= qty_new - qtys[scan_ptr];
              price_addr     <= op_id;
            end else if (scan_end) begin
              if (full_c) begin
                err <= 1'b1;
              end else begin
                ids[count_ptr]  <= op_id;
                qtys[count_ptr] <= op_qty;
                count           <= count + CNT_W'(1);
                delta           <= op_qty;
                price_addr      <= op_id;
              end
            end else begin
              scan_idx <= scan_idx + CNT_W'(1);
            end
          end
        end
        S_PRICE_WAIT: price_lat <= Price_Data;
        S_ACCUM: begin
          if (delta != '0) begin
            total <= sub_mode ? tot_sub : tot_add;
            delta <= delta - QTY_W'(1);
          end
        end
        S_SHIFT: begin
          if (shift_more) begin
            ids[scan_ptr]  <= ids[next_ptr];
            qtys[scan_ptr] <= qtys[next_ptr];
            scan_idx       <= scan_idx + CNT_W'(1);
          end else begin
            ids[last_ptr]  <= '0;
            qtys[last_ptr] <= '0;
            count          <= count - CNT_W'(1);
          end
        end
        S_CLEAR: begin
          for (int i = 0; i < MAX_ITEMS; i++) begin
            ids[i]  <= '0;
            qtys[i] <= '0;
          end
          count <= '0;
          total <= '0;
        end
        default: ;
      endcase
    end
  end

  // Display read port returns zero past the valid entries
  always_comb begin
    Rd_ProductID = '0;
    Rd_Quantity  = '0;
    if (CNT_W'(Rd_Index) < count) begin
      Rd_ProductID = ids[Rd_Index];
      Rd_Quantity  = qtys[Rd_Index];
    end
  end

  assign Price_Addr       = price_addr;
  assign BasketProductNum = count;
  assign Total            = total;
  assign Busy             = busy;
  assign Full             = full_c;
  assign Err_Pulse        = err;

endmodule
